stopwatch_display_scan: RTL and testbench

- Downstream consumer of the stopwatch counter's nine BCD digits (hours, minutes, seconds, milliseconds).
- Drives a 4-digit, time-multiplexed, common-anode 7-segment display.
- Provides three display pages (hh.mm / mm.ss / ss.ms), a lap-freeze toggle, a stability filter for digits crossing from the 1 kHz counter domain, and anti-ghosting blanking between digit switches.
- All logic runs on the board clock, negative edge.

---
 rtl/stopwatch_display_scan.sv | 167 ++++++++++++++++
 tb/tb_stopwatch_display_scan.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_display_scan.sv
// Four-digit multiplexed 7-segment driver for the stopwatch BCD digits.
// Provides paging, lap freeze, an input stability filter and anti-ghost blanking.
module stopwatch_display_scan #(
  parameter int SCAN_DIV = 50000,
  parameter int BLANK    = 2
) (
  input  logic       NEclk,
  input  logic       reset,
  input  logic [3:0] bcd_h_1,
  input  logic [3:0] bcd_h_0,
  input  logic [3:0] bcd_min_1,
  input  logic [3:0] bcd_min_0,
  input  logic [3:0] bcd_s_1,
  input  logic [3:0] bcd_s_0,
  input  logic [3:0] bcd_ms_2,
  input  logic [3:0] bcd_ms_1,
  input  logic [3:0] bcd_ms_0,
  input  logic       page_btn,
  input  logic       lap_btn,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frozen,
  output logic [1:0] page
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PS_BLANK = PW'(BLANK);

  logic [35:0]   bcd_all;
  logic [35:0]   prev;
  logic [35:0]   disp;
  logic          page_q;
  logic          lap_q;
  logic [PW-1:0] prescaler;
  logic [1:0]    index;

  logic          stable;
  logic          page_edge;
  logic          lap_edge;
  logic          blank_slot;
  logic          lz_blank;
  logic [3:0]    digit;
  logic [6:0]    seg_dec;
  logic [3:0]    an_next;
  logic [6:0]    seg_next;
  logic          dp_next;

  assign bcd_all = {bcd_h_1, bcd_h_0, bcd_min_1, bcd_min_0,
                    bcd_s_1, bcd_s_0, bcd_ms_2, bcd_ms_1, bcd_ms_0};

  assign stable    = (bcd_all == prev);
  assign page_edge = page_btn & ~page_q;
  assign lap_edge  = lap_btn & ~lap_q;

  // Digit shown at the current scan position; ms0 is never selected.
  always_comb begin
    digit = disp[23:20];
    case ({page, index})
      4'b00_11: digit = disp[35:32];
      4'b00_10: digit = disp[31:28];
      4'b00_01: digit = disp[27:24];
      4'b00_00: digit = disp[23:20];
      4'b01_11: digit = disp[27:24];
      4'b01_10: digit = disp[23:20];
      4'b01_01: digit = disp[19:16];
      4'b01_00: digit = disp[15:12];
      4'b10_11: digit = disp[19:16];
      4'b10_10: digit = disp[15:12];
      4'b10_01: digit = disp[11:8];
      4'b10_00: digit = disp[7:4];
      default:  digit = disp[23:20];
    endcase
  end

  always_comb begin
    seg_dec = 7'b0111111;
    case (digit)
      4'd0:    seg_dec = 7'b1000000;
      4'd1:    seg_dec = 7'b1111001;
      4'd2:    seg_dec = 7'b0100100;
      4'd3:    seg_dec = 7'b0110000;
      4'd4:    seg_dec = 7'b0011001;
      4'd5:    seg_dec = 7'b0010010;
      4'd6:    seg_dec = 7'b0000010;
      4'd7:    seg_dec = 7'b1111000;
      4'd8:    seg_dec = 7'b0000000;
      4'd9:    seg_dec = 7'b0010000;
      default: seg_dec = 7'b0111111;
    endcase
  end

  // Anodes stay off at the start of each slot so the old segments never ghost.
  assign blank_slot = (prescaler < PS_BLANK);
  assign lz_blank   = (page == 2'd0) && (index == 2'd3) && (disp[35:32] == 4'd0);

  always_comb begin
    an_next  = 4'b1111;
    seg_next = 7'b1111111;
    dp_next  = 1'b1;
    if (!blank_slot) begin
      seg_next = seg_dec;
      dp_next  = (index != 2'd2);
      if (!lz_blank) begin
        an_next = ~(4'b0001 << index);
      end
    end
  end

  // Filter and freeze: disp only takes values that held for two edges.
  always_ff @(negedge NEclk or posedge reset) begin
    if (reset) begin
      prev <= '0;
      disp <= '0;
    end else begin
      prev <= bcd_all;
      if (stable && !frozen) begin
        disp <= bcd_all;
      end
    end
  end

  always_ff @(negedge NEclk or posedge reset) begin
    if (reset) begin
      page_q <= 1'b0;
      lap_q  <= 1'b0;
      page   <= 2'd0;
      frozen <= 1'b0;
    end else begin
      page_q <= page_btn;
      lap_q  <= lap_btn;
      if (page_edge) begin
        page <= (page == 2'd2) ? 2'd0 : page + 2'd1;
      end
      if (lap_edge) begin
        frozen <= ~frozen;
      end
    end
  end

  always_ff @(negedge NEclk or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
      index     <= 2'd0;
    end else if (prescaler == PS_LAST) begin
      prescaler <= '0;
      index     <= index + 2'd1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // Display outputs are registered from the pre-edge scan state.
  always_ff @(negedge NEclk or posedge reset) begin
    if (reset) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_stopwatch_display_scan.sv
// Scoreboard bench: driver pushes expected outputs from a behavioural model,
// a separate monitor pops and compares after every falling clock edge.
module tb_stopwatch_display_scan;

  localparam int SD = 4;
  localparam int BL = 1;

  logic        NEclk = 1'b1;
  logic        reset = 1'b0;
  logic [35:0] bcd = '0;
  logic        page_btn = 1'b0;
  logic        lap_btn = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frozen;
  logic [1:0]  page;

  always #5 NEclk = ~NEclk;

  stopwatch_display_scan #(.SCAN_DIV(SD), .BLANK(BL)) dut (
    .NEclk(NEclk), .reset(reset),
    .bcd_h_1(bcd[35:32]), .bcd_h_0(bcd[31:28]),
    .bcd_min_1(bcd[27:24]), .bcd_min_0(bcd[23:20]),
    .bcd_s_1(bcd[19:16]), .bcd_s_0(bcd[15:12]),
    .bcd_ms_2(bcd[11:8]), .bcd_ms_1(bcd[7:4]), .bcd_ms_0(bcd[3:0]),
    .page_btn(page_btn), .lap_btn(lap_btn),
    .an(an), .seg(seg), .dp(dp), .frozen(frozen), .page(page)
  );

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       seg_care;
    logic       dp;
    logic [1:0] page;
    logic       frozen;
    int         cyc;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad = 0;

  int          m_cyc;
  logic [35:0] m_disp;
  logic [35:0] m_prev;
  logic [1:0]  m_page;
  logic        m_frozen;
  logic        m_pb;
  logic        m_lb;

  // Active-low pattern built from the list of lit segment letters.
  function automatic logic [6:0] seg_for(input logic [3:0] v);
    string lit;
    logic [6:0] s;
    s = 7'b1111111;
    case (v)
      4'd0: lit = "abcdef";
      4'd1: lit = "bc";
      4'd2: lit = "abdeg";
      4'd3: lit = "abcdg";
      4'd4: lit = "bcfg";
      4'd5: lit = "acdfg";
      4'd6: lit = "acdefg";
      4'd7: lit = "abc";
      4'd8: lit = "abcdefg";
      4'd9: lit = "abcdfg";
      default: lit = "g";
    endcase
    for (int i = 0; i < lit.len(); i++) begin
      s[int'(lit.getc(i)) - 97] = 1'b0;
    end
    return s;
  endfunction

  function automatic logic [35:0] mk(input int h, input int m, input int s, input int ms);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
            4'(ms / 100), 4'((ms / 10) % 10), 4'(ms % 10)};
  endfunction

  task automatic model_reset();
    m_cyc = 0;
    m_disp = '0;
    m_prev = '0;
    m_page = 2'd0;
    m_frozen = 1'b0;
    m_pb = 1'b0;
    m_lb = 1'b0;
    sbq.delete();
  endtask

  // One falling edge: outputs from the state before the edge, then state update.
  task automatic model_edge();
    exp_t e;
    int phase, pos, k;
    logic blank;
    phase = m_cyc % SD;
    pos = (m_cyc / SD) % 4;
    blank = (phase < BL);
    k = pos + 5 - 2 * int'(m_page);
    e.an = blank ? 4'b1111 : ~(4'b0001 << pos);
    if (!blank && m_page == 2'd0 && pos == 3 && m_disp[35:32] == 4'd0) e.an = 4'b1111;
    e.seg_care = (e.an != 4'b1111);
    e.seg = seg_for(m_disp[k*4 +: 4]);
    e.dp = !(!blank && pos == 2);
    if (bcd == m_prev && !m_frozen) m_disp = bcd;
    m_prev = bcd;
    if (page_btn && !m_pb) m_page = (m_page == 2'd2) ? 2'd0 : m_page + 2'd1;
    if (lap_btn && !m_lb) m_frozen = !m_frozen;
    m_pb = page_btn;
    m_lb = lap_btn;
    e.page = m_page;
    e.frozen = m_frozen;
    e.cyc = m_cyc;
    sbq.push_back(e);
    m_cyc++;
  endtask

  task automatic applyStimulus(input logic [35:0] v, input logic pb, input logic lb);
    @(posedge NEclk);
    bcd = v;
    page_btn = pb;
    lap_btn = lb;
    model_edge();
  endtask

  task automatic checkOutput(input string name);
    total++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1 || page !== 2'd0 || frozen !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s: an=%b seg=%b dp=%b page=%0d frozen=%b, required an=1111 seg=1111111 dp=1 page=0 frozen=0",
               name, an, seg, dp, page, frozen);
    end
  endtask

  // Reset asserted between edges; outputs must go dark before any clock edge.
  task automatic midReset(input string name);
    @(posedge NEclk);
    #2 reset = 1'b1;
    #1 checkOutput(name);
    model_reset();
    #5 reset = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    logic ok;
    forever begin
      @(negedge NEclk);
      #2;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        total++;
        ok = (an === e.an) && (dp === e.dp) && (page === e.page) && (frozen === e.frozen) &&
             (!e.seg_care || seg === e.seg);
        if (!ok) begin
          bad++;
          $display("[TB] FAIL cycle%0d: an=%b seg=%b dp=%b page=%0d frozen=%b, required an=%b seg=%b(care=%b) dp=%b page=%0d frozen=%b",
                   e.cyc, an, seg, dp, page, frozen, e.an, e.seg, e.seg_care, e.dp, e.page, e.frozen);
        end
      end
    end
  end

  initial begin : driver
    logic [35:0] v;
    logic pb, lb;
    model_reset();
    #2 reset = 1'b1;
    #1 checkOutput("reset_initial");
    #5 reset = 1'b0;

    v = mk(12, 34, 56, 789);
    repeat (20) applyStimulus(v, 1'b0, 1'b0);

    for (int p = 0; p < 3; p++) begin
      applyStimulus(v, 1'b1, 1'b0);
      repeat (17) applyStimulus(v, 1'b0, 1'b0);
    end
    repeat (10) applyStimulus(v, 1'b1, 1'b0);
    repeat (8) applyStimulus(v, 1'b0, 1'b0);

    v = mk(12, 34, 41, 789);
    repeat (3) applyStimulus(v, 1'b0, 1'b0);
    applyStimulus(v, 1'b0, 1'b1);
    v = mk(12, 34, 42, 789);
    repeat (16) applyStimulus(v, 1'b0, 1'b0);
    applyStimulus(v, 1'b0, 1'b1);
    repeat (16) applyStimulus(v, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      v[15:12] = (i % 2 == 0) ? 4'd3 : 4'd4;
      applyStimulus(v, 1'b0, 1'b0);
    end
    v[15:12] = 4'd4;
    repeat (16) applyStimulus(v, 1'b0, 1'b0);

    v = mk(5, 34, 56, 789);
    v[23:20] = 4'hC;
    applyStimulus(v, 1'b1, 1'b0);
    applyStimulus(v, 1'b0, 1'b0);
    applyStimulus(v, 1'b1, 1'b0);
    repeat (20) applyStimulus(v, 1'b0, 1'b0);

    midReset("reset_midscan");
    repeat (20) applyStimulus(v, 1'b0, 1'b0);

    pb = 1'b0;
    lb = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) midReset("reset_random");
      if ($urandom_range(0, 3) == 0) v[$urandom_range(0, 8)*4 +: 4] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) v = {$urandom(), 4'($urandom())};
      if ($urandom_range(0, 19) == 0) pb = !pb;
      if ($urandom_range(0, 29) == 0) lb = !lb;
      applyStimulus(v, pb, lb);
    end

    #20;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: pending=%0d, required pending=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
